// File: rtl/qspi_flash_responder_pkg.sv
// Shared constants for the quad I/O fast-read flash responder.
package qspi_flash_responder_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic [7:0] CMD_QIO_FAST_READ = 8'hEB;
    localparam logic [3:0] MODE_CONT_NIB     = 4'hA;

    localparam logic [CNT_W-1:0] CMD_END  = 8'd7;
    localparam logic [CNT_W-1:0] ADDR_BEG = 8'd8;
    localparam logic [CNT_W-1:0] ADDR_END = 8'd13;
    localparam logic [CNT_W-1:0] MODE_END = 8'd15;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_REJECT = 3'd5;

    // Tick counter that sticks at its maximum during long bursts.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/qspi_resp_shifter.sv
// Nibble shifter: command/address/mode capture and read-data nibble driver.
module qspi_resp_shifter
    import qspi_flash_responder_pkg::*;
#(
    parameter int unsigned MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        io_in,
    input  logic              cmd_shift,
    input  logic              addr_shift,
    input  logic              mode_ld,
    input  logic              nib_hi,
    input  logic              nib_lo,
    input  logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        cmd_next_c,
    output logic [MEM_AW-1:0] addr,
    output logic [3:0]        mode_hi,
    output logic [3:0]        io_out
);

    logic [7:0] cmd_sr;
    logic       byte_vld;
    logic [7:0] byte_buf;
    logic [7:0] byte_src_c;

    assign cmd_next_c = {cmd_sr[6:0], io_in[0]};
    // Fresh memory data bypasses the buffer when the nibble tick lands on it.
    assign byte_src_c = byte_vld ? mem_rdata : byte_buf;

    // Only the low MEM_AW address bits are kept; upper nibbles shift out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_sr   <= '0;
            addr     <= '0;
            mode_hi  <= '0;
            byte_vld <= 1'b0;
            byte_buf <= '0;
            io_out   <= '0;
        end else begin
            byte_vld <= mem_rd;
            if (cmd_shift)  cmd_sr  <= cmd_next_c;
            if (addr_shift) addr    <= {addr[MEM_AW-5:0], io_in};
            if (mode_ld)    mode_hi <= io_in;
            if (byte_vld)   byte_buf <= mem_rdata;
            if (nib_hi)      io_out <= byte_src_c[7:4];
            else if (nib_lo) io_out <= byte_src_c[3:0];
        end
    end

endmodule

// File: rtl/qspi_flash_responder.sv
// Quad I/O fast-read (0xEB) flash responder with continuous-read mode.
module qspi_flash_responder
    import qspi_flash_responder_pkg::*;
#(
    parameter int unsigned MEM_AW    = 16,
    parameter int unsigned DUMMY_NIB = 4   // must be >= 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ce_n,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic              io_oe,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [CNT_W-1:0] FETCH_AT = CNT_W'(14 + DUMMY_NIB);
    localparam logic [CNT_W-1:0] HI0_AT   = CNT_W'(15 + DUMMY_NIB);

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              cont_mode, cont_mode_nxt;
    logic              phase, phase_nxt;
    logic              io_oe_nxt, busy_nxt, cmd_err_nxt, mem_rd_nxt;
    logic [MEM_AW-1:0] mem_addr_nxt;

    logic              tick_c;
    logic              cmd_shift_c, addr_shift_c, mode_ld_c, nib_hi_c, nib_lo_c;
    logic [7:0]        cmd_next_c;
    logic [MEM_AW-1:0] addr_q;
    logic [3:0]        mode_hi_q;

    assign tick_c = ~ce_n & sck;

    qspi_resp_shifter #(.MEM_AW(MEM_AW)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .io_in      (io_in),
        .cmd_shift  (cmd_shift_c),
        .addr_shift (addr_shift_c),
        .mode_ld    (mode_ld_c),
        .nib_hi     (nib_hi_c),
        .nib_lo     (nib_lo_c),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .cmd_next_c (cmd_next_c),
        .addr       (addr_q),
        .mode_hi    (mode_hi_q),
        .io_out     (io_out)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        cont_mode_nxt = cont_mode;
        phase_nxt     = phase;
        io_oe_nxt     = io_oe;
        busy_nxt      = busy;
        cmd_err_nxt   = 1'b0;
        mem_rd_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        cmd_shift_c   = 1'b0;
        addr_shift_c  = 1'b0;
        mode_ld_c     = 1'b0;
        nib_hi_c      = 1'b0;
        nib_lo_c      = 1'b0;

        if (ce_n) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
            io_oe_nxt = 1'b0;
            busy_nxt  = 1'b0;
            phase_nxt = 1'b0;
        end else begin
            if (tick_c && state != ST_IDLE && state != ST_REJECT)
                count_nxt = cnt_inc(count);

            case (state)
                ST_IDLE: begin
                    busy_nxt = 1'b1;
                    if (cont_mode) begin
                        state_nxt = ST_ADDR;
                        count_nxt = ADDR_BEG;
                    end else begin
                        state_nxt = ST_CMD;
                        count_nxt = '0;
                    end
                end
                ST_CMD: begin
                    if (tick_c) begin
                        cmd_shift_c = 1'b1;
                        if (count == CMD_END) begin
                            if (cmd_next_c != CMD_QIO_FAST_READ) begin
                                cmd_err_nxt = 1'b1;
                                busy_nxt    = 1'b0;
                                state_nxt   = ST_REJECT;
                            end else begin
                                state_nxt = ST_ADDR;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (tick_c) begin
                        if (count <= ADDR_END) begin
                            addr_shift_c = 1'b1;
                        end else if (count != MODE_END) begin
                            mode_ld_c = 1'b1;
                        end else begin
                            cont_mode_nxt = (mode_hi_q == MODE_CONT_NIB);
                            state_nxt     = ST_DUMMY;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (tick_c && count == HI0_AT) begin
                        state_nxt = ST_DATA;
                        nib_hi_c  = 1'b1;
                        phase_nxt = 1'b1;
                        io_oe_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    // Next byte is fetched while the current high nibble is on the bus.
                    if (tick_c) begin
                        if (phase) begin
                            nib_lo_c     = 1'b1;
                            phase_nxt    = 1'b0;
                            mem_rd_nxt   = 1'b1;
                            mem_addr_nxt = mem_addr + MEM_AW'(1);
                        end else begin
                            nib_hi_c  = 1'b1;
                            phase_nxt = 1'b1;
                        end
                    end
                end
                ST_REJECT: state_nxt = ST_REJECT;
                default:   state_nxt = ST_IDLE;
            endcase

            if (tick_c && count == FETCH_AT && (state == ST_ADDR || state == ST_DUMMY)) begin
                mem_rd_nxt   = 1'b1;
                mem_addr_nxt = addr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            cont_mode <= 1'b0;
            phase     <= 1'b0;
            io_oe     <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            cont_mode <= cont_mode_nxt;
            phase     <= phase_nxt;
            io_oe     <= io_oe_nxt;
            busy      <= busy_nxt;
            cmd_err   <= cmd_err_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_addr  <= mem_addr_nxt;
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Table-driven bench: initiator-side sequences against a scoreboard of expected nibbles.
module tb_qspi_flash_responder;

    localparam int unsigned MEM_AW = 16;
    localparam int unsigned DUMMY  = 4;
    localparam int          D      = 16 + DUMMY;

    logic              clk = 1'b0;
    logic              rst;
    logic              sck;
    logic              ce_n;
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic              io_oe;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic              busy;
    logic              cmd_err;

    logic [7:0] mem [0:65535];

    int n_pass = 0;
    int n_chk  = 0;
    int err_pulses = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        bit          use_cmd;
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [7:0]  mode;
        int          nbytes;
        int          stop_at;
        bit          do_rst;
        bit          exp_err;
        bit          exp_cont;
    } txn_t;

    txn_t tv[10];

    always #5 clk = ~clk;

    qspi_flash_responder #(.MEM_AW(MEM_AW), .DUMMY_NIB(DUMMY)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .ce_n      (ce_n),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
    always @(negedge clk) if (cmd_err) err_pulses <= err_pulses + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] exp_nib(input txn_t t, input int n);
        int unsigned a;
        logic [7:0]  b;
        a = (int'(t.addr) + n / 2) % 65536;
        b = 8'(a) ^ 8'h5A;
        return (n % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [3:0] stim(input txn_t t, input int k);
        if (k < 8)   return {3'b000, t.cmd[7-k]};
        if (k < 14)  return t.addr[4*(13-k) +: 4];
        if (k == 14) return t.mode[7:4];
        if (k == 15) return t.mode[3:0];
        return 4'h0;
    endfunction

    task automatic run_txn(input int r, input txn_t t);
        int   start;
        int   stop;
        int   err0;
        logic oe_bad;
        logic [3:0] got_exp;
        start  = t.use_cmd ? 0 : 8;
        stop   = (t.stop_at != 0) ? t.stop_at : (t.exp_err ? 16 : D + 2 * t.nbytes);
        err0   = err_pulses;
        oe_bad = 1'b0;
        @(negedge clk);
        ce_n = 1'b0;
        sck  = 1'b0;
        for (int k = start; k < stop; k++) begin
            @(negedge clk);
            if (k == start) chk($sformatf("row%0d busy_start", r), 32'(busy), 32'd1);
            if (t.exp_err) oe_bad = oe_bad | io_oe;
            else chk($sformatf("row%0d oe@%0d", r, k), 32'(io_oe), 32'(k >= D));
            if (k >= D) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("row%0d queue_underrun@%0d", r, k), 32'(exp_q.size()), 32'd1);
                end else begin
                    got_exp = exp_q.pop_front();
                    chk($sformatf("row%0d nib@%0d", r, k), 32'(io_out), 32'(got_exp));
                end
            end
            // The tick driven now registers nibble k+1.
            if (!t.exp_err && k + 1 >= D && k + 1 < stop) exp_q.push_back(exp_nib(t, k + 1 - D));
            sck   = 1'b1;
            io_in = stim(t, k);
            @(negedge clk);
            sck = 1'b0;
        end
        if (t.exp_err) begin
            chk($sformatf("row%0d oe_in_reject", r), 32'(oe_bad), 32'd0);
            chk($sformatf("row%0d busy_in_reject", r), 32'(busy), 32'd0);
        end
        if (t.do_rst) begin
            @(negedge clk);
            rst  = 1'b1;
            ce_n = 1'b1;
            #1;
            chk($sformatf("row%0d oe_at_rst", r), 32'(io_oe), 32'd0);
            chk($sformatf("row%0d busy_at_rst", r), 32'(busy), 32'd0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            @(negedge clk);
            ce_n = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("row%0d busy_end", r), 32'(busy), 32'd0);
            chk($sformatf("row%0d oe_end", r), 32'(io_oe), 32'd0);
        end
        chk($sformatf("row%0d cont_mode", r), 32'(dut.cont_mode), 32'(t.exp_cont));
        chk($sformatf("row%0d cmd_err_pulses", r), 32'(err_pulses - err0), 32'(t.exp_err));
        chk($sformatf("row%0d queue_empty", r), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;

        //        cmd?  cmd    addr          mode   nb  stop     rst   err   cont
        tv[0] = '{1'b1, 8'hEB, 24'h000120, 8'hA5, 16, 0,       1'b0, 1'b0, 1'b1};
        tv[1] = '{1'b0, 8'h00, 24'h000340, 8'h00, 16, 0,       1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b1, 8'h03, 24'h000000, 8'h00, 0,  0,       1'b0, 1'b1, 1'b0};
        tv[3] = '{1'b1, 8'hEB, 24'h00FFFE, 8'h00, 4,  0,       1'b0, 1'b0, 1'b0};
        tv[4] = '{1'b1, 8'hEB, 24'h000500, 8'hA0, 0,  11,      1'b0, 1'b0, 1'b0};
        tv[5] = '{1'b1, 8'hEB, 24'h000010, 8'hA0, 3,  0,       1'b0, 1'b0, 1'b1};
        tv[6] = '{1'b0, 8'h00, 24'h000777, 8'h00, 0,  11,      1'b0, 1'b0, 1'b1};
        tv[7] = '{1'b0, 8'h00, 24'h000200, 8'hA3, 2,  0,       1'b0, 1'b0, 1'b1};
        tv[8] = '{1'b0, 8'h00, 24'h000300, 8'hA0, 4,  D + 3,   1'b1, 1'b0, 1'b0};
        tv[9] = '{1'b1, 8'hEB, 24'h000001, 8'h00, 2,  0,       1'b0, 1'b0, 1'b0};

        rst   = 1'b1;
        ce_n  = 1'b1;
        sck   = 1'b0;
        io_in = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst io_out",   32'(io_out),   32'd0);
        chk("rst io_oe",    32'(io_oe),    32'd0);
        chk("rst mem_rd",   32'(mem_rd),   32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst busy",     32'(busy),     32'd0);
        chk("rst cmd_err",  32'(cmd_err),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 10; r++) run_txn(r, tv[r]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable Quad I/O SPI flash device end (responder) for the XIP flash-read initiator.
- Decodes the QUAD I/O FAST READ (0xEB) sequence, including continuous-read mode (command skipped after mode nibble 0xA), and streams bytes from a byte-wide memory port.
- Used as an on-chip flash stand-in for FPGA/emulation builds and for closed-loop bench checks of the initiator.
- Shares clk with the initiator; sck and ce_n are synchronous to clk, so no synchronizers are used.

Parameters:
- MEM_AW, 16, byte-address width of the backing memory; the 24-bit flash address is truncated to MEM_AW bits.
- DUMMY_NIB, 4, dummy sck cycles between the mode byte and the first data nibble.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sck  in  1  serial clock from the initiator
- ce_n  in  1  chip enable, active-low
- io_in  in  4  IO lines driven by the initiator
- io_out  out  4  IO lines driven by the responder
- io_oe  out  1  responder drives io_out when 1
- mem_rd  out  1  one-cycle read strobe
- mem_addr  out  MEM_AW  byte address
- mem_rdata  in  8  read data, valid the cycle after mem_rd
- busy  out  1  ce_n low and the transaction has not been rejected
- cmd_err  out  1  one-cycle pulse on a non-0xEB command

Behaviour:
- Reset values: io_out=0, io_oe=0, mem_rd=0, mem_addr=0, busy=0, cmd_err=0; cont_mode=0; count=0; state IDLE.
- Tick: a posedge clk with ce_n==0 and sck==1. All protocol sampling happens on ticks. count (8 bit) increments on every tick.
- Data ordering by count:
  - count 0..7: command bits, MSB first, sampled from io_in[0].
  - count 8..13: address nibbles A[23:20] down to A[3:0].
  - count 14..15: mode nibbles M[7:4], M[3:0].
  - count 16..15+DUMMY_NIB: dummy.
  - From D=16+DUMMY_NIB on: data, high nibble then low nibble of each byte.
- States:
  - IDLE: on ce_n falling, go to CMD with count=0 if cont_mode==0; otherwise go to ADDR with count=8.
  - CMD: after tick 7, if the command != 0xEB, pulse cmd_err and go to REJECT; else go to ADDR.
  - ADDR: covers counts 8..15. After the count-15 tick, latch cont_mode = (M[7:4]==4'hA) and go to DUMMY.
  - DUMMY, then DATA.
  - REJECT: ignore all ticks and keep io_oe=0 until ce_n rises.
- Every state returns to IDLE, with count=0, io_oe=0 and busy=0, on the first clk edge that sees ce_n==1. A mid-transaction abort leaves cont_mode unchanged unless the count-15 tick already occurred.
- Fetch timing:
  - mem_addr=A[MEM_AW-1:0] and mem_rd=1 on the tick where count==D-2; the byte is captured the next cycle.
  - Each subsequent byte is fetched on the tick that presents its predecessor's high nibble.
  - The address increments by 1 per byte and wraps modulo 2^MEM_AW.
- Drive timing:
  - Nibble n (count==D+n) must be on io_out throughout the cycle in which count==D+n and sck==1. It is registered at the tick that moved count to D+n.
  - io_oe=1 from count D until ce_n rises; io_oe=0 at all other times, including during dummy cycles.
- Unbounded burst: data continues until ce_n high. count saturates at 255, and nibble sequencing uses a separate parity bit and the byte address, so bursts longer than the count range stay correct.
- Simultaneous events: a ce_n rise on the same edge as a tick means the tick is ignored. rst overrides everything, including cont_mode.

Decomposition:
- Shared package: CMD_QIO_FAST_READ=8'hEB, MODE_CONT_NIB=4'hA, count boundaries (CMD_END=7, ADDR_END=13, MODE_END=15), state encoding.
- One sub-module, qspi_resp_shifter: shifts nibbles in and out, and holds the address/mode capture registers.
- The FSM and the fetch logic live in the top.

Test Plan:
- Memory preloaded mem[i]=i[7:0]^8'h5A. Cold read: cmd 0xEB, address 0x000120, mode 0xA5, 4 dummy cycles, 32 nibbles. Required: bytes 0x7A,0x7B,...,0x75 (16 bytes), io_oe rises at count 20, cont_mode=1.
- Following transaction with no command (counts from 8): address 0x000340, mode 0x00 -> 16 bytes starting 0x1A; cont_mode=0 afterwards.
- Transaction after that, starting with command 0x03 -> cmd_err pulses exactly once, io_oe stays 0, busy drops when ce_n rises.
- MEM_AW=16, address 0x00FFFE, 4-byte burst -> returns mem[FFFE], mem[FFFF], mem[0000], mem[0001] (wrap).
- ce_n deasserted at count 11 -> next ce_n fall restarts at count 0 (cont_mode untouched); a full 0xEB read then succeeds.
- rst pulsed during DATA -> io_oe=0 and busy=0 immediately; cont_mode cleared, so the next transaction expects a command.
